asoc_readout_framer: RTL and testbench

- Captures fixed-length, multi-channel ASOC sample windows on an MCP trigger.
- Buffers each window on chip, then serialises it as a framed 32-bit stream on the DAQ path: header, channel-major sample words, trailer.
- Sits between the ASOC data-bus capture logic and the host/DAQ FIFO in the FPGA top level.
- Generalises single-channel readout to N_CH channels, adds configurable window length, capture timeout and dropped-trigger accounting.

---
 rtl/asoc_readout_pkg.sv | 24 ++
 rtl/asoc_window_buf.sv | 64 ++++++
 rtl/asoc_readout_framer.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_asoc_readout_framer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asoc_readout_pkg.sv
// Shared definitions for the ASOC readout framer.
// Holds the frame marker bytes, the framer state encoding and a helper that
// computes the 8-bit frame length field carried in the trailer.
package asoc_readout_pkg;

    localparam logic [7:0] HDR_MARK = 8'hA5;
    localparam logic [7:0] TRL_MARK = 8'hE0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_HEADER  = 3'd2,
        ST_DATA    = 3'd3,
        ST_TRAILER = 3'd4
    } state_e;

    // Words per frame (header + samples + trailer), truncated to 8 bits.
    function automatic logic [7:0] frame_words(input int unsigned n_ch, input int unsigned win_len);
        int unsigned total;
        total = (n_ch * win_len) + 32'd2;
        return total[7:0];
    endfunction

endpackage

// File: rtl/asoc_window_buf.sv
// Window buffer: simple dual-port RAM of DEPTH beats x WIDTH bits.
// Synchronous write, registered read (1-cycle latency, holds while rd_en=0),
// and a one-cycle clear pulse that zeroes every entry so beats that are never
// written during a truncated capture read back as 0.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset of the read register
//   clr      - zero the whole array (takes priority over a write)
//   wr_en    - write wr_data to wr_addr
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - load rd_data from rd_addr
//   rd_addr  - read address
//   rd_data  - registered read data
module asoc_window_buf #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 48,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Storage array: bulk clear on capture start, otherwise single-beat writes.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_enifdef_guard(wr_en)) begin
            mem_r[wr_addr] <= wr_data;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    // Registered read port; holds its value when no read is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

    function automatic logic wr_enifdef_guard(input logic en);
        return en;
    endfunction

endmodule

// File: rtl/asoc_readout_framer.sv
// ASOC readout framer.
// Captures a WINDOW_LEN-beat window of N_CH parallel samples after a trigger,
// then streams it as 32-bit words: header, channel-major samples, trailer.
// Ports:
//   clk_sys          - system clock, all logic on rising edge
//   rst_sys          - synchronous active-high reset (abandons any frame)
//   asoc_trig_in     - trigger level, sampled every cycle
//   asoc_data_valid  - asoc_data_bus carries a beat this cycle
//   asoc_data_bus    - channel c in bits [c*SAMPLE_W +: SAMPLE_W]
//   daq_data_out     - registered frame word
//   daq_valid        - daq_data_out is valid (AXI-stream style)
//   daq_last         - marks the trailer word
//   daq_ready        - downstream accepts when daq_valid && daq_ready
//   busy             - high whenever the framer is not idle
module asoc_readout_framer
    import asoc_readout_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int SAMPLE_W   = 12,
    parameter int WINDOW_LEN = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                       clk_sys,
    input  logic                       rst_sys,
    input  logic                       asoc_trig_in,
    input  logic                       asoc_data_valid,
    input  logic [N_CH*SAMPLE_W-1:0]   asoc_data_bus,
    output logic [31:0]                daq_data_out,
    output logic                       daq_valid,
    output logic                       daq_last,
    input  logic                       daq_ready,
    output logic                       busy
);

    localparam int BUS_W = N_CH * SAMPLE_W;
    localparam int IDX_W = $clog2(WINDOW_LEN);
    localparam int CH_W  = (N_CH > 32'd1) ? $clog2(N_CH) : 32'd1;
    localparam int TMO_W = $clog2(TIMEOUT + 32'd1);

    localparam logic [7:0]       N_CH_B      = 8'(N_CH);
    localparam logic [7:0]       FRAME_WORDS = frame_words(N_CH, WINDOW_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(WINDOW_LEN - 32'd1);
    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(N_CH - 32'd1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 32'd1);

    // Registered state
    state_e           state_r;
    logic [IDX_W-1:0] wr_idx_r;
    logic [TMO_W-1:0] tmo_r;
    logic             trunc_r;
    logic [CH_W-1:0]  rd_ch_r;
    logic [IDX_W-1:0] rd_idx_r;
    logic             trl_loaded_r;
    logic [15:0]      trig_cnt_r;
    logic [7:0]       drop_cnt_r;
    logic [31:0]      daq_data_r;
    logic             daq_valid_r;
    logic             daq_last_r;
    logic             hdr_out_r;
    logic             busy_r;

    // Next-state / control signals
    state_e           state_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [TMO_W-1:0] tmo_s;
    logic             trunc_s;
    logic [CH_W-1:0]  rd_ch_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic             trl_loaded_s;
    logic             buf_clr_s;
    logic             buf_wr_s;
    logic             buf_rd_s;
    logic [IDX_W-1:0] buf_rd_addr_s;
    logic [BUS_W-1:0] buf_rd_data_s;
    logic             load_s;
    logic [31:0]      load_word_s;
    logic             load_last_s;
    logic             load_hdr_s;
    logic             out_free_s;
    logic             hs_s;
    logic             trl_done_s;
    logic [SAMPLE_W-1:0] sample_s;
    logic [31:0]      data_word_s;
    logic [31:0]      trailer_word_s;

    asoc_window_buf #(
        .DEPTH  (WINDOW_LEN),
        .WIDTH  (BUS_W),
        .ADDR_W (IDX_W)
    ) u_buf (
        .clk     (clk_sys),
        .rst     (rst_sys),
        .clr     (buf_clr_s),
        .wr_en   (buf_wr_s),
        .wr_addr (wr_idx_r),
        .wr_data (asoc_data_bus),
        .rd_en   (buf_rd_s),
        .rd_addr (buf_rd_addr_s),
        .rd_data (buf_rd_data_s)
    );

    // The output slot can take a new word when empty or when its word leaves now.
    assign out_free_s = !daq_valid_r || daq_ready;
    assign hs_s       = daq_valid_r && daq_ready;
    assign trl_done_s = (state_r == ST_TRAILER) && trl_loaded_r && hs_s;

    // The prefetched beat holds all channels; pick the one being emitted.
    assign sample_s       = buf_rd_data_s[rd_ch_r*SAMPLE_W +: SAMPLE_W];
    assign data_word_s    = {8'(rd_ch_r), 8'(rd_idx_r), 16'(sample_s)};
    assign trailer_word_s = {TRL_MARK, trunc_r, 7'b0000000, drop_cnt_r, FRAME_WORDS};

    // Next-state and datapath control for capture and readout.
    always_comb begin
        state_s       = state_r;
        wr_idx_s      = wr_idx_r;
        tmo_s         = tmo_r;
        trunc_s       = trunc_r;
        rd_ch_s       = rd_ch_r;
        rd_idx_s      = rd_idx_r;
        trl_loaded_s  = trl_loaded_r;
        buf_clr_s     = 1'b0;
        buf_wr_s      = 1'b0;
        buf_rd_s      = 1'b0;
        buf_rd_addr_s = rd_idx_r;
        load_s        = 1'b0;
        load_word_s   = 32'h0000_0000;
        load_last_s   = 1'b0;
        load_hdr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (asoc_trig_in) begin
                    state_s      = ST_CAPTURE;
                    buf_clr_s    = 1'b1;
                    wr_idx_s     = {IDX_W{1'b0}};
                    tmo_s        = {TMO_W{1'b0}};
                    trunc_s      = 1'b0;
                    rd_ch_s      = {CH_W{1'b0}};
                    rd_idx_s     = {IDX_W{1'b0}};
                    trl_loaded_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                tmo_s = tmo_r + 1'b1;
                if (asoc_data_valid) begin
                    buf_wr_s = 1'b1;
                    wr_idx_s = wr_idx_r + 1'b1;
                end else begin
                    wr_idx_s = wr_idx_r;
                end
                // A completed window wins over a coincident timeout.
                if (asoc_data_valid && (wr_idx_r == IDX_LAST)) begin
                    state_s = ST_HEADER;
                end else if (tmo_r == TMO_LAST) begin
                    trunc_s = 1'b1;
                    state_s = ST_HEADER;
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            ST_HEADER: begin
                if (out_free_s) begin
                    load_s        = 1'b1;
                    load_word_s   = {HDR_MARK, trig_cnt_r, N_CH_B};
                    load_hdr_s    = 1'b1;
                    // Prefetch beat 0 so the first data word is ready next cycle.
                    buf_rd_s      = 1'b1;
                    buf_rd_addr_s = rd_idx_r;
                    state_s       = ST_DATA;
                end else begin
                    state_s = ST_HEADER;
                end
            end
            ST_DATA: begin
                if (out_free_s) begin
                    load_s      = 1'b1;
                    load_word_s = data_word_s;
                    buf_rd_s    = 1'b1;
                    if (rd_idx_r == IDX_LAST) begin
                        rd_idx_s = {IDX_W{1'b0}};
                        if (rd_ch_r == CH_LAST) begin
                            state_s = ST_TRAILER;
                        end else begin
                            rd_ch_s = rd_ch_r + 1'b1;
                            state_s = ST_DATA;
                        end
                    end else begin
                        rd_idx_s = rd_idx_r + 1'b1;
                        state_s  = ST_DATA;
                    end
                    // Prefetch the beat for the word that follows this one.
                    buf_rd_addr_s = rd_idx_s;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_TRAILER: begin
                if (!trl_loaded_r) begin
                    if (out_free_s) begin
                        load_s       = 1'b1;
                        load_word_s  = trailer_word_s;
                        load_last_s  = 1'b1;
                        trl_loaded_s = 1'b1;
                    end else begin
                        trl_loaded_s = 1'b0;
                    end
                    state_s = ST_TRAILER;
                end else if (hs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_TRAILER;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM and capture/readout pointer registers.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_r      <= ST_IDLE;
            wr_idx_r     <= {IDX_W{1'b0}};
            tmo_r        <= {TMO_W{1'b0}};
            trunc_r      <= 1'b0;
            rd_ch_r      <= {CH_W{1'b0}};
            rd_idx_r     <= {IDX_W{1'b0}};
            trl_loaded_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            wr_idx_r     <= wr_idx_s;
            tmo_r        <= tmo_s;
            trunc_r      <= trunc_s;
            rd_ch_r      <= rd_ch_s;
            rd_idx_r     <= rd_idx_s;
            trl_loaded_r <= trl_loaded_s;
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    // Output word register: load a new word or empty the slot after a handshake.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            daq_data_r  <= 32'h0000_0000;
            daq_valid_r <= 1'b0;
            daq_last_r  <= 1'b0;
            hdr_out_r   <= 1'b0;
        end else if (load_s) begin
            daq_data_r  <= load_word_s;
            daq_valid_r <= 1'b1;
            daq_last_r  <= load_last_s;
            hdr_out_r   <= load_hdr_s;
        end else if (hs_s) begin
            daq_data_r  <= daq_data_r;
            daq_valid_r <= 1'b0;
            daq_last_r  <= 1'b0;
            hdr_out_r   <= 1'b0;
        end else begin
            daq_data_r  <= daq_data_r;
            daq_valid_r <= daq_valid_r;
            daq_last_r  <= daq_last_r;
            hdr_out_r   <= hdr_out_r;
        end
    end

    // Frame counter advances only once the header word has been accepted.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            trig_cnt_r <= 16'h0000;
        end else if (hs_s && hdr_out_r) begin
            trig_cnt_r <= trig_cnt_r + 16'd1;
        end else begin
            trig_cnt_r <= trig_cnt_r;
        end
    end

    // Dropped-trigger counter: saturating, restarted when the trailer is accepted.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            drop_cnt_r <= 8'h00;
        end else if (trl_done_s) begin
            drop_cnt_r <= asoc_trig_in ? 8'h01 : 8'h00;
        end else if (asoc_trig_in && (state_r != ST_IDLE) && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign daq_data_out = daq_data_r;
    assign daq_valid    = daq_valid_r;
    assign daq_last     = daq_last_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_asoc_readout_framer.sv
// Scoreboard bench for asoc_readout_framer: stimulus pushes expected frame
// words into a queue, a negedge monitor pops and compares on every handshake
// and also checks that a stalled word stays put.
module tb_asoc_readout_framer;

    localparam int N_CH       = 4;
    localparam int SAMPLE_W   = 12;
    localparam int WINDOW_LEN = 16;
    localparam int TIMEOUT    = 1024;
    localparam int BUS_W      = N_CH * SAMPLE_W;

    logic             clk_sys = 1'b0;
    logic             rst_sys = 1'b1;
    logic             asoc_trig_in = 1'b0;
    logic             asoc_data_valid = 1'b0;
    logic [BUS_W-1:0] asoc_data_bus = '0;
    logic [31:0]      daq_data_out;
    logic             daq_valid;
    logic             daq_last;
    logic             daq_ready = 1'b0;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int ready_mode = 1;   // 0: low, 1: high, 2: random
    bit sb_enable = 1'b1;
    logic [32:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    logic        prev_last  = 1'b0;

    always #5 clk_sys = ~clk_sys;

    asoc_readout_framer #(
        .N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .WINDOW_LEN(WINDOW_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_sys         (clk_sys),
        .rst_sys         (rst_sys),
        .asoc_trig_in    (asoc_trig_in),
        .asoc_data_valid (asoc_data_valid),
        .asoc_data_bus   (asoc_data_bus),
        .daq_data_out    (daq_data_out),
        .daq_valid       (daq_valid),
        .daq_last        (daq_last),
        .daq_ready       (daq_ready),
        .busy            (busy)
    );

    // Downstream ready generator
    always @(posedge clk_sys) begin
        #1;
        case (ready_mode)
            0:       daq_ready = 1'b0;
            1:       daq_ready = 1'b1;
            default: daq_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: stall stability and scoreboard comparison on each handshake
    always @(negedge clk_sys) begin
        logic [32:0] exp_w;
        if (rst_sys) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!daq_valid || daq_data_out !== prev_data || daq_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%08h last=%0b, need valid=1 data=%08h last=%0b",
                             daq_valid, daq_data_out, daq_last, prev_data, prev_last);
                end
            end
            if (daq_valid && daq_ready) begin
                hs_cnt++;
                if (sb_enable) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_word: got %08h last=%0b, need no word", daq_data_out, daq_last);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if ({daq_last, daq_data_out} !== exp_w) begin
                            errors++;
                            $display("FAIL frame_word #%0d: got data=%08h last=%0b, need data=%08h last=%0b",
                                     hs_cnt, daq_data_out, daq_last, exp_w[31:0], exp_w[32]);
                        end
                    end
                end
            end
            prev_stall = daq_valid && !daq_ready;
            prev_data  = daq_data_out;
            prev_last  = daq_last;
        end
    end

    // Watchdog
    initial begin
        repeat (50000) @(posedge clk_sys);
        $display("FAIL watchdog: got no end after 50000 cycles, need finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [BUS_W-1:0] beat(input int idx);
        logic [BUS_W-1:0] b;
        b = '0;
        for (int c = 0; c < N_CH; c++) begin
            b[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(32'h100 * c + idx);
        end
        return b;
    endfunction

    task automatic push_frame(input logic [31:0] hdr, input int n_valid, input logic [31:0] trl);
        logic [15:0] smp;
        exp_q.push_back({1'b0, hdr});
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int idx = 0; idx < WINDOW_LEN; idx++) begin
                smp = (idx < n_valid) ? 16'(32'h100 * ch + idx) : 16'h0000;
                exp_q.push_back({1'b0, 8'(ch), 8'(idx), smp});
            end
        end
        exp_q.push_back({1'b1, trl});
    endtask

    task automatic pulse_trig();
        asoc_trig_in = 1'b1;
        tick();
        asoc_trig_in = 1'b0;
    endtask

    task automatic drive_beats(input int n);
        for (int i = 0; i < n; i++) begin
            asoc_data_valid = 1'b1;
            asoc_data_bus   = beat(i);
            tick();
        end
        asoc_data_valid = 1'b0;
        asoc_data_bus   = '0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || daq_valid) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy || daq_valid) begin
            errors++;
            $display("FAIL %s_drain: got %0d words pending busy=%0b, need 0 pending and idle",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s: got %0b, need %0b", name, got, need);
        end
    endtask

    initial begin
        int lat;
        int n;
        int base;

        repeat (3) tick();
        rst_sys = 1'b0;
        tick();

        // Reset state
        check_bit("reset_valid", daq_valid, 1'b0);
        check_bit("reset_last", daq_last, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        checks++;
        if (daq_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %08h, need 00000000", daq_data_out);
        end

        // Basic frame, ready always high
        ready_mode = 1;
        push_frame(32'hA500_0004, 16, 32'hE000_0042);
        pulse_trig();
        drive_beats(16);
        wait_drain("basic");

        // Same frame under random backpressure
        ready_mode = 2;
        push_frame(32'hA500_0104, 16, 32'hE000_0042);
        pulse_trig();
        drive_beats(16);
        wait_drain("backpressure");
        ready_mode = 1;
        tick();

        // 300 triggers while busy: drop field saturates
        ready_mode = 0;
        tick();
        push_frame(32'hA500_0204, 16, 32'hE000_FF42);
        pulse_trig();
        for (int i = 0; i < 300; i++) begin
            asoc_trig_in    = 1'b1;
            asoc_data_valid = (i < 16);
            asoc_data_bus   = (i < 16) ? beat(i) : '0;
            tick();
        end
        asoc_trig_in    = 1'b0;
        asoc_data_valid = 1'b0;
        asoc_data_bus   = '0;
        ready_mode = 1;
        wait_drain("drops");

        // Truncated window: 5 beats then timeout; header count only one higher
        push_frame(32'hA500_0304, 5, 32'hE080_0042);
        pulse_trig();
        lat = 0;
        while (!daq_valid && lat < 1100) begin
            if (lat < 5) begin
                asoc_data_valid = 1'b1;
                asoc_data_bus   = beat(lat);
            end else begin
                asoc_data_valid = 1'b0;
                asoc_data_bus   = '0;
            end
            tick();
            lat++;
        end
        asoc_data_valid = 1'b0;
        asoc_data_bus   = '0;
        checks++;
        if (lat != TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_latency: got header after %0d cycles, need %0d", lat, TIMEOUT + 1);
        end
        wait_drain("truncated");

        // Reset in the middle of DATA
        sb_enable = 1'b0;
        base = hs_cnt;
        pulse_trig();
        drive_beats(16);
        n = 0;
        while (hs_cnt < base + 30 && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (hs_cnt < base + 30) begin
            errors++;
            $display("FAIL midframe_reach: got %0d words, need 30", hs_cnt - base);
        end
        rst_sys = 1'b1;
        tick();
        check_bit("midreset_valid", daq_valid, 1'b0);
        check_bit("midreset_busy", busy, 1'b0);
        check_bit("midreset_last", daq_last, 1'b0);
        rst_sys = 1'b0;
        tick();
        sb_enable = 1'b1;
        push_frame(32'hA500_0004, 16, 32'hE000_0042);
        pulse_trig();
        drive_beats(16);
        wait_drain("after_reset");

        // Frame counter wrap via preloaded value
        force dut.trig_cnt_r = 16'hFFFF;
        tick();
        release dut.trig_cnt_r;
        tick();
        push_frame(32'hA5FF_FF04, 16, 32'hE000_0042);
        pulse_trig();
        drive_beats(16);
        wait_drain("wrap_ffff");
        push_frame(32'hA500_0004, 16, 32'hE000_0042);
        pulse_trig();
        drive_beats(16);
        wait_drain("wrap_0000");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
